// File: rtl/bsg_flow_throttle.sv
// bsg_flow_throttle: hysteresis admission control (clk_i, reset_n_i, count_i, v_i -> ready_o, enque_o; clear_stall_i -> stall_count_o; error_o sticky on count_i > els_p)
module bsg_flow_throttle #(
  parameter int els_p = 64,
  parameter int hi_mark_p = 56,
  parameter int lo_mark_p = 32,
  parameter int stall_width_p = 16,
  localparam int count_width_lp = $clog2(els_p+1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [count_width_lp-1:0] count_i,
  input  logic                      v_i,
  output logic                      ready_o,
  output logic                      enque_o,
  input  logic                      clear_stall_i,
  output logic [stall_width_p-1:0]  stall_count_o,
  output logic                      error_o
);
  if (!(lo_mark_p >= 0 && lo_mark_p < hi_mark_p && hi_mark_p <= els_p)) begin : g_bad_params
    $error("bsg_flow_throttle: illegal watermark parameters");
  end
  typedef enum logic {OPEN, THROTTLED} state_e;
  state_e state_r, state_n;
  logic [count_width_lp:0] proj;
  logic over;
  assign over = int'(count_i) > els_p;
  assign ready_o = (state_r == OPEN) & (int'(count_i) < els_p);
  assign enque_o = v_i & ready_o;
  assign proj = {1'b0, count_i} + {{count_width_lp{1'b0}}, enque_o};
  always_comb begin
    state_n = (error_o | over) ? THROTTLED
            : (state_r == OPEN) ? ((int'(proj) >= hi_mark_p) ? THROTTLED : OPEN)
            : ((int'(count_i) <= lo_mark_p) ? OPEN : THROTTLED);
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= OPEN;
    else state_r <= state_n;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_count_o <= '0;
      error_o <= 1'b0;
    end else begin
      error_o <= error_o | over;
      stall_count_o <= clear_stall_i ? '0
                     : (v_i & ~ready_o & ~&stall_count_o) ? stall_count_o + stall_width_p'(1)
                     : stall_count_o;
    end
  end
endmodule

// File: doc/bsg_flow_throttle.md
# bsg_flow_throttle

Upstream admission controller for a buffer whose occupancy is tracked by `bsg_flow_counter`. It takes the counter's registered occupancy and drives the `ready` seen by the producer. A two-state hysteresis FSM throttles the producer at a high watermark and releases it at a low watermark. Its `enque_o` output drives the counter's `v_i`/`ready_i` pair, closing the loop. It also keeps a saturating stall-cycle counter and a sticky occupancy-error flag.

## Interface
- `els_p`, 64, buffer capacity in elements; `count_i` never legally exceeds it
- `hi_mark_p`, 56, projected occupancy at or above which the producer is throttled
- `lo_mark_p`, 32, occupancy at or below which the producer is released
- `stall_width_p`, 16, width of the stall-cycle counter
- `count_width_lp`, derived as `$clog2(els_p+1)`, width of the occupancy input (7 at defaults)
- Legal parameters: `0 <= lo_mark_p < hi_mark_p <= els_p`. Violations are an elaboration error.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge
- `reset_n_i`  in  1  asynchronous, active-low reset
- `count_i`  in  `count_width_lp`  occupancy from `bsg_flow_counter.count_o`
- `v_i`  in  1  producer valid
- `ready_o`  out  1  producer ready
- `enque_o`  out  1  accepted transfer (`v_i & ready_o`); wired to the counter's `v_i`, with the counter's `ready_i` tied high
- `clear_stall_i`  in  1  synchronous clear of `stall_count_o`
- `stall_count_o`  out  `stall_width_p`  saturating count of cycles with `v_i & ~ready_o`
- `error_o`  out  1  sticky; set if `count_i > els_p` is ever sampled

## Operation
- FSM states: OPEN and THROTTLED.
- Projected occupancy is `proj = count_i + enque_o`, computed at `count_width_lp+1` bits so it cannot wrap. Dequeues are deliberately ignored, which keeps the projection conservative.
- In OPEN: if `proj >= hi_mark_p`, go to THROTTLED next cycle; otherwise stay.
- In THROTTLED: if `count_i <= lo_mark_p`, go to OPEN next cycle; otherwise stay.
- `ready_o = (state == OPEN) & (count_i < els_p)`.
  - The full-capacity term is a safety override: the buffer can never be overfilled, even with `hi_mark_p == els_p`.
- `enque_o = v_i & ready_o`. It has no other qualifiers.
- Stall counter, in priority order:
  - `clear_stall_i` sets it to 0. Clear wins over a simultaneous stall cycle, so the result is 0, not 1.
  - Otherwise, on a cycle with `v_i & ~ready_o`, it increments.
  - At all-ones it holds (saturates) and never wraps.
- `error_o` sets when `count_i > els_p` is sampled on a clock edge. Only `reset_n_i` clears it.
- While `error_o` is set, the FSM is forced to THROTTLED and stays there until reset.

## Timing
- Reset (`reset_n_i` low) takes effect immediately, independent of the clock:
  - state = OPEN, `stall_count_o` = 0, `error_o` = 0
  - `ready_o` follows `count_i < els_p` combinationally, so with `count_i` = 0 it reads 1 during reset
- Reset deassertion is synchronised externally; the block does not re-synchronise it.
- Reset asserted mid-throttle returns the FSM to OPEN at once. The stall count is discarded.
- `ready_o` depends only on the state flop and `count_i` (itself a flop output). There is no combinational path from `v_i` to `ready_o`.
- `enque_o` is combinational from `v_i`, one gate deep.
- Throttle latency: the transfer that makes `proj` reach `hi_mark_p` is accepted, and `ready_o` falls the following cycle.
- Release latency: `ready_o` rises one cycle after `count_i <= lo_mark_p` is first sampled in THROTTLED.

## Test plan
- Reset/idle:
  - Hold `reset_n_i` low with `count_i` = 0 → `ready_o` = 1, `stall_count_o` = 0, `error_o` = 0.
  - Raise `reset_n_i` → no change.
- Throttle entry:
  - Defaults, `count_i` = 55, `v_i` = 1 → `enque_o` = 1 this cycle, then `ready_o` = 0 the next cycle, with `count_i` = 56.
- Hysteresis release:
  - In THROTTLED, step `count_i` 40 → 33 → 32 → `ready_o` stays 0 through 33, and is 1 the cycle after 32 is sampled.
  - Raising `count_i` to 50 afterwards keeps `ready_o` = 1.
- Full override:
  - `hi_mark_p` = 64, `count_i` = 64, state OPEN → `ready_o` = 0 and `enque_o` = 0 with `v_i` = 1.
- Stall counter:
  - 5 throttled cycles with `v_i` = 1 → `stall_count_o` = 5.
  - `clear_stall_i` together with a stall cycle → 0.
  - With `stall_width_p` = 4, 20 stall cycles → 15 and holding.
- Error/async reset:
  - `count_i` = 65 for one cycle → `error_o` = 1, `ready_o` = 0 persistently, even after `count_i` returns to 0.
  - Pulse `reset_n_i` low between clock edges → `error_o` = 0 immediately and `ready_o` = 1.
